// File: rtl/timer_pkg.sv
// Shared definitions for the down-counting tick timer: FSM state encoding
// and the prescaler division ratio used when TIMER_PRESCALE_EN is defined.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } timer_state_t;

  localparam int PRESCALE_DIV = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-PRESCALE_DIV strobe generator; Clear restarts the
// phase so the first strobe after a Start/Stop is a full PRESCALE_DIV clocks away.
module tick_prescaler
  import timer_pkg::*;
(
  input  logic Clock,
  input  logic Resetn,
  input  logic Clear,
  output logic Strobe
);

  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE_DIV - 1);

  logic [PW-1:0] phase;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      phase <= '0;
    end else if (Clear || (phase == LAST)) begin
      phase <= '0;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  assign Strobe = (phase == LAST);

endmodule

// File: rtl/down_tick_timer.sv
// Loadable down-counting period timer with one-shot/periodic modes, pause,
// abort and a one-cycle Tick at every period end. Optional macro
// TIMER_PRESCALE_EN gates count steps with a tick_prescaler strobe.
module down_tick_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Enable,
  input  logic             Mode,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] CountValue,
  output logic             Tick,
  output logic             Busy,
  output logic             Err
);

  timer_state_t     state_q, state_next;
  logic [WIDTH-1:0] count_q, count_next;
  logic [WIDTH-1:0] period_q, period_next;
  logic             mode_q, mode_next;
  logic             tick_q, tick_next;
  logic             err_q, err_next;
  logic             step_ok;

`ifdef TIMER_PRESCALE_EN
  tick_prescaler u_prescaler (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Clear  (Start | Stop),
    .Strobe (step_ok)
  );
`else
  assign step_ok = 1'b1;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_next;
      count_q  <= count_next;
      period_q <= period_next;
      mode_q   <= mode_next;
      tick_q   <= tick_next;
      err_q    <= err_next;
    end
  end

  // Stop beats Start beats counting; a rejected Start (zero period) freezes the
  // timer for that edge and only raises Err.
  always_comb begin
    state_next  = state_q;
    count_next  = count_q;
    period_next = period_q;
    mode_next   = mode_q;
    tick_next   = 1'b0;
    err_next    = 1'b0;

    if (Stop) begin
      state_next = IDLE;
      count_next = '0;
    end else if (Start) begin
      if (LoadValue != '0) begin
        state_next  = RUN;
        count_next  = LoadValue;
        period_next = LoadValue;
        mode_next   = Mode;
      end else begin
        err_next = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (!Enable) begin
            state_next = PAUSE;
          end else if (step_ok) begin
            if (count_q > WIDTH'(1)) begin
              count_next = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
              tick_next = 1'b1;
              if (mode_q) begin
                count_next = period_q;
              end else begin
                count_next = '0;
                state_next = IDLE;
              end
            end else begin
              // A zero count in RUN can only come from corruption; park safely.
              state_next = IDLE;
            end
          end
        end
        PAUSE: begin
          if (Enable) begin
            state_next = RUN;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign CountValue = count_q;
  assign Tick       = tick_q;
  assign Err        = err_q;
  assign Busy       = (state_q == RUN) || (state_q == PAUSE);

endmodule

// File: tb/tb_down_tick_timer.sv
// Self-checking bench for down_tick_timer: directed scenarios plus random
// traffic compared every cycle against a behavioural period model.
module tb_down_tick_timer;
  import timer_pkg::*;

  localparam int WIDTH = 8;

  logic             Clock;
  logic             Resetn;
  logic             Start;
  logic             Stop;
  logic             Enable;
  logic             Mode;
  logic [WIDTH-1:0] LoadValue;
  logic [WIDTH-1:0] CountValue;
  logic             Tick;
  logic             Busy;
  logic             Err;

  int num_checks = 0;
  int num_fails  = 0;

  // Behavioural model: "active" timer with a remaining count and a period.
  bit mdl_active;
  bit mdl_paused;
  bit mdl_periodic;
  int mdl_remaining;
  int mdl_period;
  bit mdl_tick;
  bit mdl_err;
  int mdl_psc_phase;

  down_tick_timer #(.WIDTH(WIDTH)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Start      (Start),
    .Stop       (Stop),
    .Enable     (Enable),
    .Mode       (Mode),
    .LoadValue  (LoadValue),
    .CountValue (CountValue),
    .Tick       (Tick),
    .Busy       (Busy),
    .Err        (Err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  task automatic model_reset();
    mdl_active    = 1'b0;
    mdl_paused    = 1'b0;
    mdl_periodic  = 1'b0;
    mdl_remaining = 0;
    mdl_period    = 0;
    mdl_tick      = 1'b0;
    mdl_err       = 1'b0;
    mdl_psc_phase = 0;
  endtask

  // One clock edge of the timer's documented behaviour.
  task automatic model_edge(input bit start, input bit stop, input bit enable,
                            input bit mode, input int load);
    bit step_allowed;
`ifdef TIMER_PRESCALE_EN
    step_allowed  = (mdl_psc_phase == PRESCALE_DIV - 1);
    mdl_psc_phase = (start || stop) ? 0 : (mdl_psc_phase + 1) % PRESCALE_DIV;
`else
    step_allowed = 1'b1;
`endif
    mdl_tick = 1'b0;
    mdl_err  = 1'b0;
    if (stop) begin
      mdl_active    = 1'b0;
      mdl_paused    = 1'b0;
      mdl_remaining = 0;
    end else if (start) begin
      if (load != 0) begin
        mdl_active    = 1'b1;
        mdl_paused    = 1'b0;
        mdl_remaining = load;
        mdl_period    = load;
        mdl_periodic  = mode;
      end else begin
        mdl_err = 1'b1;
      end
    end else if (mdl_active) begin
      if (mdl_paused) begin
        if (enable) mdl_paused = 1'b0;
      end else if (!enable) begin
        mdl_paused = 1'b1;
      end else if (step_allowed) begin
        mdl_remaining = mdl_remaining - 1;
        if (mdl_remaining == 0) begin
          mdl_tick = 1'b1;
          if (mdl_periodic) mdl_remaining = mdl_period;
          else mdl_active = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    check_output({tag, ".count"}, 32'(CountValue), 32'(mdl_remaining));
    check_output({tag, ".tick"},  32'(Tick),       32'(mdl_tick));
    check_output({tag, ".busy"},  32'(Busy),       32'(mdl_active));
    check_output({tag, ".err"},   32'(Err),        32'(mdl_err));
  endtask

  // Drive inputs away from the edge, clock once, advance model, sample #1 later.
  task automatic apply_stimulus(input string tag, input bit start, input bit stop,
                                input bit enable, input bit mode, input int load);
    Start     = start;
    Stop      = stop;
    Enable    = enable;
    Mode      = mode;
    LoadValue = WIDTH'(load);
    @(posedge Clock);
    model_edge(start, stop, enable, mode, load);
    #1;
    compare_model(tag);
    @(negedge Clock);
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    Resetn = 1'b0;
    #1;
    model_reset();
    check_output({tag, ".rst_count"}, 32'(CountValue), 32'd0);
    check_output({tag, ".rst_tick"},  32'(Tick),       32'd0);
    check_output({tag, ".rst_busy"},  32'(Busy),       32'd0);
    check_output({tag, ".rst_err"},   32'(Err),        32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  initial begin
    Resetn    = 1'b0;
    Start     = 1'b0;
    Stop      = 1'b0;
    Enable    = 1'b0;
    Mode      = 1'b0;
    LoadValue = '0;
    model_reset();
    #12;
    check_output("reset.count", 32'(CountValue), 32'd0);
    check_output("reset.busy",  32'(Busy),       32'd0);
    check_output("reset.tick",  32'(Tick),       32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);

    // Periodic N=5 free run.
    apply_stimulus("per5_start", 1, 0, 1, 1, 5);
    check_output("per5_loaded", 32'(CountValue), 32'd5);
    for (int i = 0; i < 12; i++) begin
      apply_stimulus("per5_run", 0, 0, 1, 0, 0);
`ifndef TIMER_PRESCALE_EN
      if (i == 4) begin
        check_output("per5_tick",   32'(Tick),       32'd1);
        check_output("per5_reload", 32'(CountValue), 32'd5);
      end
`endif
    end
    apply_stimulus("stop", 0, 1, 1, 0, 0);

    // One-shot N=3.
    apply_stimulus("os3_start", 1, 0, 1, 0, 3);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus("os3_run", 0, 0, 1, 0, 0);
`ifndef TIMER_PRESCALE_EN
      if (i == 2) begin
        check_output("os3_tick", 32'(Tick), 32'd1);
        check_output("os3_idle", 32'(Busy), 32'd0);
      end
`endif
    end

    // Rejected zero-period Start.
    apply_stimulus("zero_start", 1, 0, 1, 1, 0);
    check_output("zero_err", 32'(Err), 32'd1);
    apply_stimulus("zero_after", 0, 0, 1, 0, 0);
    check_output("zero_err_gone", 32'(Err), 32'd0);

    // Periodic N=4 paused at count 2.
    apply_stimulus("pause_start", 1, 0, 1, 1, 4);
    apply_stimulus("pause_run", 0, 0, 1, 0, 0);
    apply_stimulus("pause_run", 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) apply_stimulus("pause_hold", 0, 0, 0, 0, 0);
`ifndef TIMER_PRESCALE_EN
    check_output("pause_count", 32'(CountValue), 32'd2);
    check_output("pause_busy",  32'(Busy),       32'd1);
`endif
    for (int i = 0; i < 4; i++) apply_stimulus("pause_resume", 0, 0, 1, 0, 0);

    // Stop and Start together at count 7.
    apply_stimulus("ss_start", 1, 0, 1, 1, 9);
    apply_stimulus("ss_run", 0, 0, 1, 0, 0);
    apply_stimulus("ss_run", 0, 0, 1, 0, 0);
    apply_stimulus("ss_both", 1, 1, 1, 1, 9);
    check_output("ss_count", 32'(CountValue), 32'd0);
    check_output("ss_busy",  32'(Busy),       32'd0);

    // Asynchronous reset mid-count, then Start required again.
    apply_stimulus("rst_start", 1, 0, 1, 1, 9);
    apply_stimulus("rst_run", 0, 0, 1, 0, 0);
    async_reset_check("midcount");
    apply_stimulus("rst_after", 0, 0, 1, 0, 0);
    apply_stimulus("rst_restart", 1, 0, 1, 0, 2);
    for (int i = 0; i < 4; i++) apply_stimulus("rst_run2", 0, 0, 1, 0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      bit r_start, r_stop, r_en, r_mode;
      int r_load;
      r_start = ($urandom_range(0, 11) == 0);
      r_stop  = ($urandom_range(0, 39) == 0);
      r_en    = ($urandom_range(0, 5) != 0);
      r_mode  = 1'($urandom_range(0, 1));
      r_load  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40))
                                            : int'($urandom_range(0, 7));
      if (i % 250 == 249) async_reset_check("rand");
      else apply_stimulus("rand", r_start, r_stop, r_en, r_mode, r_load);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
